// File: rtl/traffic_light_monitor.sv
// Passive lamp-side checker for the traffic-light controller.
// Decodes {red,orange,green} each clock, tracks phase order and per-phase
// duration, and reports lock, completed periods and the first fault cause.
module traffic_light_monitor #(
  parameter int unsigned RED_LEN    = 2,
  parameter int unsigned RED_OR_LEN = 1,
  parameter int unsigned GREEN_LEN  = 8,
  parameter int unsigned ORANGE_LEN = 2,
  parameter int unsigned CNT_W      = 16,
  parameter bit          RESYNC     = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             red_i,
  input  logic             orange_i,
  input  logic             green_i,
  output logic [2:0]       phase_o,
  output logic             locked_o,
  output logic             cycle_done_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic             fault_o,
  output logic [2:0]       fault_code_o
);

  // state     | meaning
  // ST_SYNC   | waiting for an orange->red edge to lock on
  // ST_RED    | tracking red-only
  // ST_RED_OR | tracking red+orange
  // ST_GREEN  | tracking green-only
  // ST_ORANGE | tracking orange-only
  // ST_FAULT  | violation seen; terminal unless RESYNC
  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_RED    = 3'd1,
    ST_RED_OR = 3'd2,
    ST_GREEN  = 3'd3,
    ST_ORANGE = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  localparam logic [2:0] P_RED    = 3'b100;
  localparam logic [2:0] P_RED_OR = 3'b110;
  localparam logic [2:0] P_GREEN  = 3'b001;
  localparam logic [2:0] P_ORANGE = 3'b010;

  localparam logic [3:0] L_RED    = 4'(RED_LEN);
  localparam logic [3:0] L_RED_OR = 4'(RED_OR_LEN);
  localparam logic [3:0] L_GREEN  = 4'(GREEN_LEN);
  localparam logic [3:0] L_ORANGE = 4'(ORANGE_LEN);

  localparam logic [2:0] C_NONE    = 3'd0;
  localparam logic [2:0] C_ILLEGAL = 3'd1;
  localparam logic [2:0] C_ORDER   = 3'd2;
  localparam logic [2:0] C_SHORT   = 3'd3;
  localparam logic [2:0] C_LONG    = 3'd4;

  state_t           state_q, state_d;
  logic [3:0]       dur_q, dur_d;
  logic [2:0]       prev_q;
  logic [2:0]       phase_q, phase_d;
  logic             locked_q, locked_d;
  logic             cycle_done_q, cycle_done_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             fault_q, fault_d;
  logic [2:0]       fault_code_q, fault_code_d;

  logic [2:0] pat;
  logic       legal;
  logic [2:0] cur_pat, succ_pat;
  logic [3:0] cur_len;
  state_t     succ_st;
  logic [2:0] cause;
  logic       wrap;

  assign pat   = {red_i, orange_i, green_i};
  assign legal = (pat == P_RED) || (pat == P_RED_OR) || (pat == P_GREEN) || (pat == P_ORANGE);

  // State, duration counter, previous pattern and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_SYNC;
      dur_q         <= '0;
      prev_q        <= '0;
      phase_q       <= '0;
      locked_q      <= 1'b0;
      cycle_done_q  <= 1'b0;
      cycle_count_q <= '0;
      fault_q       <= 1'b0;
      fault_code_q  <= '0;
    end else begin
      state_q       <= state_d;
      dur_q         <= dur_d;
      prev_q        <= pat;
      phase_q       <= phase_d;
      locked_q      <= locked_d;
      cycle_done_q  <= cycle_done_d;
      cycle_count_q <= cycle_count_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
    end
  end

  // Next state: priority illegal > same phase > successor > any other legal pattern
  always_comb begin
    state_d  = state_q;
    dur_d    = dur_q;
    cause    = C_NONE;
    wrap     = 1'b0;
    cur_pat  = P_RED;
    succ_pat = P_RED_OR;
    cur_len  = L_RED;
    succ_st  = ST_RED_OR;
    case (state_q)
      ST_RED_OR: begin cur_pat = P_RED_OR; succ_pat = P_GREEN;  cur_len = L_RED_OR; succ_st = ST_GREEN;  end
      ST_GREEN:  begin cur_pat = P_GREEN;  succ_pat = P_ORANGE; cur_len = L_GREEN;  succ_st = ST_ORANGE; end
      ST_ORANGE: begin cur_pat = P_ORANGE; succ_pat = P_RED;    cur_len = L_ORANGE; succ_st = ST_RED;    end
      default:   begin cur_pat = P_RED;    succ_pat = P_RED_OR; cur_len = L_RED;    succ_st = ST_RED_OR; end
    endcase
    case (state_q)
      ST_SYNC: begin
        if (prev_q == P_ORANGE && pat == P_RED) begin
          state_d = ST_RED;
          dur_d   = 4'd1;
        end
      end
      ST_RED, ST_RED_OR, ST_GREEN, ST_ORANGE: begin
        if (!legal) begin
          cause = C_ILLEGAL;
        end else if (pat == cur_pat) begin
          if (dur_q == cur_len) cause = C_LONG;
          else                  dur_d = dur_q + 4'd1;
        end else if (pat == succ_pat) begin
          if (dur_q != cur_len) begin
            cause = C_SHORT;
          end else begin
            state_d = succ_st;
            dur_d   = 4'd1;
            wrap    = (state_q == ST_ORANGE);
          end
        end else begin
          cause = C_ORDER;
        end
        if (cause != C_NONE) state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (RESYNC) state_d = ST_SYNC;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // Output values for the upcoming state, registered above
  always_comb begin
    phase_d       = 3'd0;
    locked_d      = 1'b0;
    if (state_d == ST_RED || state_d == ST_RED_OR || state_d == ST_GREEN || state_d == ST_ORANGE) begin
      phase_d  = state_d;
      locked_d = 1'b1;
    end
    cycle_done_d  = wrap;
    cycle_count_d = cycle_count_q;
    if (wrap && cycle_count_q != {CNT_W{1'b1}}) cycle_count_d = cycle_count_q + 1'b1;
    fault_d       = fault_q | (cause != C_NONE);
    fault_code_d  = (fault_code_q == C_NONE) ? cause : fault_code_q;
  end

  assign phase_o       = phase_q;
  assign locked_o      = locked_q;
  assign cycle_done_o  = cycle_done_q;
  assign cycle_count_o = cycle_count_q;
  assign fault_o       = fault_q;
  assign fault_code_o  = fault_code_q;

endmodule
